// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Read-side consumer of the async FIFO (R_CLK domain). Whenever the block is
// idle, enabled and the FIFO is non-empty it pops one byte and serializes it
// as a UART frame: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit, stop bit(s).
//
// Optional build macro: UART_TX_TWO_STOP_EN -> two stop bits (STOP = 2*P).
//
// Ports:
//   CLK        FIFO read clock, rising edge
//   RST        synchronous active-high reset
//   TX_EN      allows FIFO pops / new frames (an in-flight frame completes)
//   PRESCALE   clocks per bit (0 treated as 1), sampled at frame fetch
//   PAR_EN     insert parity bit, sampled at frame fetch
//   PAR_TYP    0 = even, 1 = odd parity, sampled at frame fetch
//   RD_DATA    FIFO read data, valid while EMPTY = 0
//   EMPTY      FIFO empty flag
//   R_INC      FIFO pop strobe (combinational, one CLK wide)
//   TX_OUT     serial line, idle high
//   BUSY       high from first START cycle to end of STOP
//   FRAME_DONE one-cycle pulse in the first IDLE cycle after a frame
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_WD   = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  TX_EN,
   input  logic [PRESC_WD-1:0]   PRESCALE,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [DATA_WIDTH-1:0] RD_DATA,
   input  logic                  EMPTY,
   output logic                  R_INC,
   output logic                  TX_OUT,
   output logic                  BUSY,
   output logic                  FRAME_DONE
);

   localparam int BCW = $clog2(DATA_WIDTH + 1);

   // Index of the last stop bit; the bit counter is reused to count stop bits.
`ifdef UART_TX_TWO_STOP_EN
   localparam logic [BCW-1:0] STOP_LAST = BCW'(1);
`else
   localparam logic [BCW-1:0] STOP_LAST = BCW'(0);
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // Parity bit: XOR of the data for even, XNOR for odd.
   function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data,
                                       input logic                  odd);
      parity_bit = (^data) ^ odd;
   endfunction

   state_t                  state_q, state_d;
   logic                    tx_out_q, tx_out_d;
   logic                    busy_q, busy_d;
   logic                    frame_done_q, frame_done_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [PRESC_WD-1:0]     presc_q, presc_d;
   logic [PRESC_WD-1:0]     pcnt_q, pcnt_d;
   logic [BCW-1:0]          bcnt_q, bcnt_d;
   logic                    par_en_q, par_en_d;
   logic                    par_bit_q, par_bit_d;
   logic                    fetch_s;
   logic                    bit_end_s;
   logic [DATA_WIDTH-1:0]   shift_next_s;

   // Next-state, datapath and output computation for the frame FSM.
   always_comb begin
      state_d      = state_q;
      tx_out_d     = tx_out_q;
      frame_done_d = 1'b0;
      shift_d      = shift_q;
      presc_d      = presc_q;
      bcnt_d       = bcnt_q;
      par_en_d     = par_en_q;
      par_bit_d    = par_bit_q;

      // Pop is combinational so the byte is latched on the same edge.
      fetch_s      = (state_q == S_IDLE) && TX_EN && !EMPTY && !RST;
      // presc_q is never 0 once a frame is fetched, so P-1 cannot underflow.
      bit_end_s    = (pcnt_q == (presc_q - PRESC_WD'(1)));
      shift_next_s = shift_q >> 1;

      if (bit_end_s) begin
         pcnt_d = '0;
      end else begin
         pcnt_d = pcnt_q + PRESC_WD'(1);
      end

      case (state_q)
         S_IDLE: begin
            tx_out_d = 1'b1;
            pcnt_d   = '0;
            bcnt_d   = '0;
            if (fetch_s) begin
               shift_d   = RD_DATA;
               presc_d   = (PRESCALE == '0) ? PRESC_WD'(1) : PRESCALE;
               par_en_d  = PAR_EN;
               // Parity taken from the byte as fetched, not the shifting copy.
               par_bit_d = parity_bit(RD_DATA, PAR_TYP);
               state_d   = S_START;
               tx_out_d  = 1'b0;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_START: begin
            if (bit_end_s) begin
               state_d  = S_DATA;
               tx_out_d = shift_q[0];
            end else begin
               state_d  = S_START;
            end
         end
         S_DATA: begin
            if (bit_end_s) begin
               if (bcnt_q == BCW'(DATA_WIDTH - 1)) begin
                  bcnt_d = '0;
                  if (par_en_q) begin
                     state_d  = S_PARITY;
                     tx_out_d = par_bit_q;
                  end else begin
                     state_d  = S_STOP;
                     tx_out_d = 1'b1;
                  end
               end else begin
                  bcnt_d   = bcnt_q + BCW'(1);
                  shift_d  = shift_next_s;
                  tx_out_d = shift_next_s[0];
               end
            end else begin
               state_d = S_DATA;
            end
         end
         S_PARITY: begin
            if (bit_end_s) begin
               state_d  = S_STOP;
               tx_out_d = 1'b1;
            end else begin
               state_d  = S_PARITY;
            end
         end
         S_STOP: begin
            tx_out_d = 1'b1;
            if (bit_end_s) begin
               if (bcnt_q == STOP_LAST) begin
                  state_d      = S_IDLE;
                  bcnt_d       = '0;
                  frame_done_d = 1'b1;
               end else begin
                  bcnt_d = bcnt_q + BCW'(1);
               end
            end else begin
               state_d = S_STOP;
            end
         end
         default: begin
            state_d  = S_IDLE;
            tx_out_d = 1'b1;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign R_INC      = fetch_s;
   assign TX_OUT     = tx_out_q;
   assign BUSY       = busy_q;
   assign FRAME_DONE = frame_done_q;

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         tx_out_q     <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         shift_q      <= '0;
         presc_q      <= PRESC_WD'(1);
         pcnt_q       <= '0;
         bcnt_q       <= '0;
         par_en_q     <= 1'b0;
         par_bit_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         tx_out_q     <= tx_out_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         shift_q      <= shift_d;
         presc_q      <= presc_d;
         pcnt_q       <= pcnt_d;
         bcnt_q       <= bcnt_d;
         par_en_q     <= par_en_d;
         par_bit_q    <= par_bit_d;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
// Directed bench for fifo_uart_tx. A small FIFO model feeds the DUT; every
// byte pushed also pushes its expected serial waveform (one entry per clock)
// onto a scoreboard queue that is popped as the DUT transmits.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;
   localparam int DW = 8;
   localparam int PW = 6;
`ifdef UART_TX_TWO_STOP_EN
   localparam int NSTOP = 2;
`else
   localparam int NSTOP = 1;
`endif

   logic          clk = 1'b0;
   logic          rst, tx_en, par_en, par_typ, empty;
   logic [PW-1:0] prescale;
   logic [DW-1:0] rd_data;
   logic          r_inc, tx_out, busy, frame_done;

   always #5 clk = ~clk;

   fifo_uart_tx #(.DATA_WIDTH(DW), .PRESC_WD(PW)) dut (
      .CLK(clk), .RST(rst), .TX_EN(tx_en), .PRESCALE(prescale),
      .PAR_EN(par_en), .PAR_TYP(par_typ), .RD_DATA(rd_data), .EMPTY(empty),
      .R_INC(r_inc), .TX_OUT(tx_out), .BUSY(busy), .FRAME_DONE(frame_done)
   );

   logic [DW-1:0] fifo_q[$];
   bit            exp_q[$];
   int            len_q[$];
   int            compared = 0;
   int            mismatched = 0;
   int            pops = 0;
   bit            pop_pend = 1'b0;
   logic          s_tx, s_busy, s_fd, s_rinc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic refresh_fifo();
      if (fifo_q.size() == 0) begin
         empty   = 1'b1;
         rd_data = '0;
      end else begin
         empty   = 1'b0;
         rd_data = fifo_q[0];
      end
   endtask

   // One clock: note the pop about to happen, let the edge pass, update the
   // FIFO model, then sample outputs on the falling edge.
   task automatic cyc();
      #2;
      pop_pend = r_inc;
      @(posedge clk);
      #1;
      if (pop_pend && fifo_q.size() > 0) begin
         void'(fifo_q.pop_front());
         pops++;
      end
      pop_pend = 1'b0;
      refresh_fifo();
      @(negedge clk);
      s_tx   = tx_out;
      s_busy = busy;
      s_fd   = frame_done;
      s_rinc = r_inc;
   endtask

   // Queue a byte in the FIFO, set frame config, and optionally its expected waveform.
   task automatic push_frame(input logic [DW-1:0] d, input logic [PW-1:0] p,
                             input bit pe, input bit pt, input bit model);
      int  pp;
      bit  par;
      fifo_q.push_back(d);
      refresh_fifo();
      prescale = p;
      par_en   = pe;
      par_typ  = pt;
      if (model) begin
         pp  = (p == 0) ? 1 : int'(p);
         par = pt;
         for (int b = 0; b < DW; b++) par = par ^ d[b];
         for (int k = 0; k < pp; k++) exp_q.push_back(1'b0);
         for (int b = 0; b < DW; b++)
            for (int k = 0; k < pp; k++) exp_q.push_back(d[b]);
         if (pe)
            for (int k = 0; k < pp; k++) exp_q.push_back(par);
         for (int k = 0; k < pp * NSTOP; k++) exp_q.push_back(1'b1);
         len_q.push_back((2 + DW + (pe ? 1 : 0) + NSTOP - 1) * pp);
      end
   endtask

   // Wait for a start bit, then check every clock of the frame against the scoreboard.
   task automatic run_frame(input string tag, input int exp_gap, input int chg_at,
                            input logic [PW-1:0] new_p, input bit drop);
      int w = 0;
      int n;
      bit lvl;
      while (s_tx !== 1'b0 && w < 300) begin
         cyc();
         w++;
      end
      chk({tag, " start_seen"}, s_tx, 1'b0);
      if (exp_gap >= 0) chk({tag, " idle_gap"}, w, exp_gap);
      n = len_q.pop_front();
      if (s_tx !== 1'b0) begin
         for (int i = 0; i < n; i++) void'(exp_q.pop_front());
         return;
      end
      for (int i = 0; i < n; i++) begin
         lvl = exp_q.pop_front();
         chk($sformatf("%s tx[%0d]", tag, i), s_tx, lvl);
         chk($sformatf("%s busy[%0d]", tag, i), s_busy, 1'b1);
         chk($sformatf("%s fdone[%0d]", tag, i), s_fd, 1'b0);
         chk($sformatf("%s rinc[%0d]", tag, i), s_rinc, 1'b0);
         if (i == chg_at) begin
            prescale = new_p;
            if (drop) tx_en = 1'b0;
         end
         cyc();
      end
      chk({tag, " fdone_end"}, s_fd, 1'b1);
      chk({tag, " busy_end"}, s_busy, 1'b0);
      chk({tag, " tx_end"}, s_tx, 1'b1);
   endtask

   initial begin
      int w;
      rst = 1'b1; tx_en = 1'b1; prescale = 6'd4; par_en = 1'b0; par_typ = 1'b0;
      refresh_fifo();

      // Reset with a byte waiting in the FIFO: nothing may move.
      push_frame(8'hA5, 6'd4, 1'b0, 1'b0, 1'b1);
      repeat (2) begin
         cyc();
         chk("rst tx", s_tx, 1'b1);
         chk("rst busy", s_busy, 1'b0);
         chk("rst rinc", s_rinc, 1'b0);
      end
      chk("rst pops", pops, 0);
      rst = 1'b0;

      // 0xA5, P=4, no parity: 40-clock frame.
      run_frame("a5", -1, -1, 6'd0, 1'b0);
      chk("a5 pops", pops, 1);

      // 0x07 with even then odd parity, P=2: 22-clock frames.
      push_frame(8'h07, 6'd2, 1'b1, 1'b0, 1'b1);
      run_frame("par_even", -1, -1, 6'd0, 1'b0);
      push_frame(8'h07, 6'd2, 1'b1, 1'b1, 1'b1);
      run_frame("par_odd", -1, -1, 6'd0, 1'b0);
      chk("par pops", pops, 3);

      // Back-to-back frames at P=1: exactly one idle clock between them.
      push_frame(8'h11, 6'd1, 1'b0, 1'b0, 1'b1);
      push_frame(8'h22, 6'd1, 1'b0, 1'b0, 1'b1);
      run_frame("b2b_1", -1, -1, 6'd0, 1'b0);
      run_frame("b2b_2", 1, -1, 6'd0, 1'b0);
      chk("b2b pops", pops, 5);

      // PRESCALE = 0 behaves as 1.
      push_frame(8'hFF, 6'd0, 1'b0, 1'b0, 1'b1);
      run_frame("p0", -1, -1, 6'd0, 1'b0);
      chk("p0 pops", pops, 6);

      // PRESCALE changed 3 -> 8 mid-frame is ignored.
      push_frame(8'h3C, 6'd3, 1'b0, 1'b0, 1'b1);
      run_frame("pchg", -1, 4, 6'd8, 1'b0);
      chk("pchg pops", pops, 7);

      // Reset in the middle of the data bits aborts the frame.
      push_frame(8'h5A, 6'd2, 1'b0, 1'b0, 1'b0);
      w = 0;
      while (s_tx !== 1'b0 && w < 50) begin
         cyc();
         w++;
      end
      chk("abort start_seen", s_tx, 1'b0);
      repeat (6) cyc();
      chk("abort in_frame", s_busy, 1'b1);
      push_frame(8'h96, 6'd2, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      cyc();
      chk("abort tx", s_tx, 1'b1);
      chk("abort busy", s_busy, 1'b0);
      chk("abort rinc", s_rinc, 1'b0);
      cyc();
      chk("abort rinc2", s_rinc, 1'b0);
      chk("abort pops", pops, 8);
      rst = 1'b0;
      run_frame("after_rst", -1, -1, 6'd0, 1'b0);
      chk("after_rst pops", pops, 9);

      // TX_EN dropped mid-frame: frame completes, next byte waits.
      push_frame(8'hC3, 6'd2, 1'b0, 1'b0, 1'b1);
      push_frame(8'h4B, 6'd2, 1'b0, 1'b0, 1'b1);
      run_frame("drop", -1, 3, 6'd2, 1'b1);
      repeat (12) begin
         cyc();
         chk("hold rinc", s_rinc, 1'b0);
         chk("hold tx", s_tx, 1'b1);
         chk("hold busy", s_busy, 1'b0);
      end
      chk("hold pops", pops, 10);
      chk("hold empty", empty, 1'b0);
      tx_en = 1'b1;
      run_frame("resume", -1, -1, 6'd0, 1'b0);
      chk("resume pops", pops, 11);
      chk("scoreboard drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer of the async FIFO, in the FIFO read clock domain.
- Pops one byte whenever the FIFO is non-empty and the block is idle.
- Serializes each byte as a UART frame: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
- Drives the serial TX line of the UART system.

Parameters:
DATA_WIDTH, 8, width of FIFO read data and of the UART data field
PRESC_WD, 6, width of the PRESCALE input (clocks per bit)

Ports:
CLK  input  1  FIFO read clock (R_CLK side); all logic on rising edge
RST  input  1  synchronous, active-high reset
TX_EN  input  1  1 = FIFO pops and new frames allowed; an in-flight frame always completes
PRESCALE  input  PRESC_WD  clocks per bit; 0 treated as 1; sampled at frame fetch
PAR_EN  input  1  1 = insert parity bit; sampled at frame fetch
PAR_TYP  input  1  0 = even, 1 = odd; sampled at frame fetch
RD_DATA  input  DATA_WIDTH  FIFO read data; valid while EMPTY = 0
EMPTY  input  1  FIFO empty flag
R_INC  output  1  FIFO pop strobe, one CLK wide
TX_OUT  output  1  serial line, idle high
BUSY  output  1  high from the first START cycle to the end of the STOP state
FRAME_DONE  output  1  one-cycle pulse in the cycle after the last stop-bit clock

Behaviour:
- Reset (RST = 1 at a rising edge):
  - state IDLE; TX_OUT = 1; BUSY = 0; FRAME_DONE = 0; R_INC = 0.
  - bit counter, prescale counter and shift register cleared.
  - Reset mid-frame aborts the frame: TX_OUT returns to 1 on the next edge, no FIFO pop.
- States:
  - IDLE: TX_OUT = 1.
    - R_INC = IDLE & TX_EN & ~EMPTY & ~RST (combinational, no register delay).
    - At the edge where R_INC = 1: latch RD_DATA into the shift register; latch PRESCALE (0 becomes 1), PAR_EN and PAR_TYP; go to START.
  - START: TX_OUT = 0 for P clocks. P is the latched prescale value.
  - DATA: DATA_WIDTH bits, LSB first, each held P clocks. The shift register shifts right at each bit boundary.
  - PARITY (only if the latched PAR_EN = 1): one bit for P clocks.
    - Bit = XOR of data when even, XNOR when odd.
    - Computed from the latched byte, not the shifting register.
  - STOP: TX_OUT = 1 for P clocks, then go to IDLE; FRAME_DONE = 1 in the first IDLE cycle.
- Timing:
  - TX_OUT falls on the edge where R_INC is sampled high, so the start bit is visible in the following cycle.
  - Back-to-back frames: exactly one IDLE cycle between the last stop clock and the next start, giving a stop width of P + 1 clocks.
  - Frame length: (1 + DATA_WIDTH + PAR_EN + 1) × P clocks.
- Prescale counter: counts 0 to P − 1; the wrap marks a bit boundary.
- Changes to PRESCALE, PAR_EN or PAR_TYP mid-frame are ignored.
- TX_EN deasserted mid-frame: the current frame finishes, then the block holds in IDLE with no pop.
- EMPTY = 1 in IDLE: no pop; R_INC stays 0 and TX_OUT stays 1.
- R_INC is never asserted outside IDLE. Exactly one pop per frame.

Optional Feature:
- Macro UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2 × P clocks (two stop bits); frame length gains P clocks.
- Undefined: one stop bit, as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset with RST = 1 for 2 cycles, EMPTY = 0 -> TX_OUT = 1, BUSY = 0, R_INC = 0 throughout reset.
- EMPTY = 0, RD_DATA = 8'hA5, PRESCALE = 4, PAR_EN = 0, TX_EN = 1 -> exactly one R_INC pulse; TX_OUT sequence 0, 1,0,1,0,0,1,0,1, 1 (each 4 clocks); FRAME_DONE one cycle after 40 clocks.
- RD_DATA = 8'h07, PAR_EN = 1, PAR_TYP = 0, then repeat with PAR_TYP = 1, PRESCALE = 2 -> parity bit 1 for even, 0 for odd; frame length 22 clocks.
- FIFO holds 8'h11 then 8'h22, EMPTY low continuously, PRESCALE = 1 -> two pops; 1 idle clock between the stop bit of frame 1 and the start bit of frame 2; both bytes serialized in order.
- PRESCALE = 0, RD_DATA = 8'hFF -> behaves as P = 1: 10-clock frame.
- Change PRESCALE from 3 to 8 mid-frame with RD_DATA = 8'h3C -> all bits of the current frame stay 3 clocks wide.
- Assert RST mid-DATA -> TX_OUT = 1 and BUSY = 0 next cycle; no extra R_INC.
- Drop TX_EN mid-frame -> frame completes; no further pop while EMPTY = 0.
- With UART_TX_TWO_STOP_EN defined, 8'hA5 and P = 4 -> stop high for 8 clocks; frame length 44 clocks.
